afifo_rd_drain: RTL and testbench
=================================

# afifo_rd_drain

Read-side consumer of the async FIFO, living entirely in the read clock domain. It pops words from the FIFO read port (`rinc`/`rempty`/`rdata`) and re-presents them as a registered valid/ready stream, with a `last` marker every `BURST_LEN` words. It is the counterpart of the write-side driver: it pulls data out of the FIFO, where the driver pushes data in. It also provides a running pop counter for status and scoreboarding.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: FIFO word width.
- `BURST_LEN`, default 16: words per burst; must be ≥ 1.
- `CNT_WIDTH`, default 32: width of the pop counter.

**Ports**
- `rclk`, input, 1: read-domain clock. Single clock.
- `rrst`, input, 1: reset, **synchronous, active-high**.
- `drain_en`, input, 1: permits popping the FIFO.
- `rempty`, input, 1: FIFO empty flag, from the FIFO.
- `rdata`, input, DATA_WIDTH: FIFO head word; valid whenever `rempty` = 0 (first-word fall-through).
- `rinc`, output, 1: pop strobe to the FIFO.
- `m_valid`, output, 1: stream word valid.
- `m_ready`, input, 1: downstream accepts the word.
- `m_data`, output, DATA_WIDTH: stream word.
- `m_last`, output, 1: final word of a burst.
- `pop_count`, output, CNT_WIDTH: total words popped; wraps modulo 2^CNT_WIDTH.

## Operation

**Skid buffer.** A 2-entry skid buffer holds {data, last}. `occ` ∈ {0, 1, 2}.

**Pop rule (combinational).** `rinc = drain_en & ~rempty & ~rrst & (occ < 2)`.
- `rinc` has no combinational dependence on `m_ready`.
- `rinc` is never asserted while `rempty` = 1 (no underflow).

**Push.** On an `rclk` edge with `rinc` = 1, `rdata` is written into the buffer tail. The entry's `last` bit is set to `(beat == BURST_LEN-1)`.

**Output.** The buffer head drives `m_data` and `m_last`. `m_valid = (occ != 0)`. A word is accepted on any edge with `m_valid & m_ready`.

**Simultaneous push and accept.** `occ` is unchanged. FIFO order is preserved.

**Beat counter.** Range 0..BURST_LEN-1. Increments on each pop and wraps to 0 after BURST_LEN-1. With `BURST_LEN` = 1, every word has `last` = 1.

**Pop counter.** `pop_count` increments on each pop.

**Disabling.** When `drain_en` goes low:
- popping stops on the same cycle;
- words already buffered are still delivered;
- the beat counter holds its value, so bursts resume seamlessly.

**Stream rules.**
- While `m_valid` = 1 and `m_ready` = 0, `m_data` and `m_last` hold stable.
- `m_valid` does not drop until the word is accepted.

**Reset.** While `rrst` = 1, on every edge:
- `occ`, the beat counter and `pop_count` are cleared to 0;
- `m_valid`, `m_data` and `m_last` are 0;
- `rinc` is held at 0.

Reset mid-burst discards any buffered words. The next pop after reset starts at beat 0.

## Timing

- **FIFO to stream latency.** A word popped at edge N is on `m_data`, with `m_valid` = 1, after edge N, in the cycle N+1.
- **Throughput.** Sustained 1 word per cycle when `rempty` = 0 and `m_ready` = 1. In steady state `occ` = 1.
- **Backpressure.**
  - `m_ready` low for k cycles fills the buffer to 2 within 2 cycles, then `rinc` drops.
  - Once `m_ready` returns, the next edge accepts a word and `occ` becomes 1. `rinc` is asserted again in that cycle.
- **Outputs.** All outputs except `rinc` come straight from flops.
- **`pop_count`.** Updates on the same edge as the pop.

## Structure

**Shared package `afifo_pkg`.**
- Entry struct `afifo_beat_t` {data, last}, parameterised by width via a typedef in the module.
- A `clog2`-based helper for sizing the beat counter.

**Sub-module `afifo_skid_buf`.**
- Generic 2-entry valid/ready buffer with in/out handshakes and an `occ` output.
- `afifo_rd_drain` adds the pop rule, the beat counter and `pop_count` around it.

## Test plan

- **Single word.** Reset for 3 cycles, `drain_en` = 1, FIFO holds 0xA5A5_0001, `m_ready` = 1.
  - `rinc` pulses once.
  - The next cycle shows `m_data` = 0xA5A5_0001, `m_valid` = 1, `m_last` = 0.
  - `pop_count` = 1.
- **Streaming burst.** `BURST_LEN` = 4, FIFO preloaded with 0..9, `m_ready` = 1.
  - `rinc` is high for 10 consecutive cycles.
  - `m_last` = 1 on words 3 and 7 only.
  - `pop_count` = 10; order preserved.
- **Backpressure.** Streaming with `m_ready` = 0 for 5 cycles.
  - `rinc` drops after 2 pops.
  - `m_data` is held stable.
  - Release yields no loss or duplication; scoreboard matches 0..N.
- **Empty and disable.** FIFO empties, or `drain_en` is dropped mid-burst at beat 2.
  - `rinc` stays 0 while `rempty` = 1.
  - Buffered words drain.
  - On re-enable, the next word's `m_last` aligns with beat 3 of the same burst.
- **Reset mid-operation.** Assert `rrst` with `occ` = 2 and beat = 2.
  - Next cycle: `m_valid` = 0, `pop_count` = 0, `rinc` = 0.
  - After release, the first pop gets beat 0.
- **Counter wrap.** `CNT_WIDTH` = 4; pop 17 words.
  - `pop_count` reads 1.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared types and helpers for the async FIFO read-side drain logic.
package afifo_pkg;

    // Skid buffer occupancy, also used directly as its state encoding.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Width of a counter covering 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/afifo_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; the head entry drives the output
// directly from a flop, the skid entry catches a word while the head is stalled.
module afifo_skid_buf
    import afifo_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    occ_e             state;
    occ_e             state_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             push;
    logic             pop;
    logic             load_head;
    logic             head_from_skid;
    logic             load_skid;

    assign in_ready  = (state != OCC_FULL);
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = head;
    assign occ       = state;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next     = state;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (push) begin
                    state_next = OCC_ONE;
                    load_head  = 1'b1;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_next = OCC_FULL;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // A full buffer never accepts, so only the drain case exists.
                if (pop) begin
                    state_next     = OCC_ONE;
                    load_head      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= OCC_EMPTY;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst)            head <= '0;
        else if (load_head) head <= head_from_skid ? skid : in_data;
    end

    // NOTE: the skid entry has no reset; it is only read after being loaded, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (load_skid) skid <= in_data;
    end

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-domain FIFO consumer: pops first-word-fall-through data into a skid
// buffer and presents it as a registered valid/ready stream with burst markers.
module afifo_rd_drain
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  drain_en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    localparam int unsigned           BEAT_W   = cnt_width(BURST_LEN);
    localparam logic [BEAT_W-1:0]     BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } afifo_beat_t;

    afifo_beat_t       in_beat;
    afifo_beat_t       out_beat;
    logic              want;
    logic              buf_ready;
    logic              push;
    logic [1:0]        occ;
    logic [BEAT_W-1:0] beat;

    // rinc looks only at local occupancy, never at m_ready, keeping the FIFO handshake short.
    assign want = drain_en & ~rempty & ~rrst;
    assign rinc = want & (occ != OCC_FULL);
    assign push = want & buf_ready;

    assign in_beat.data = rdata;
    assign in_beat.last = (beat == BEAT_MAX);

    afifo_skid_buf #(
        .WIDTH ($bits(afifo_beat_t))
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .in_valid  (want),
        .in_ready  (buf_ready),
        .in_data   (in_beat),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (out_beat),
        .occ       (occ)
    );

    assign m_data = out_beat.data;
    assign m_last = out_beat.last;

    // Beat position holds while popping is paused so a burst resumes where it stopped.
    always_ff @(posedge rclk) begin
        if (rrst)      beat <= '0;
        else if (push) beat <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
    end

    always_ff @(posedge rclk) begin
        if (rrst)      pop_count <= '0;
        else if (push) pop_count <= pop_count + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Self-checking bench for afifo_rd_drain: a queue-based FIFO source and a
// stream scoreboard derived from the pop/last/count rules, plus directed checks.
module tb_afifo_rd_drain;

    localparam int DW    = 32;
    localparam int BL    = 4;
    localparam int CNT_W = 4;

    logic             rclk = 1'b0;
    logic             rrst;
    logic             drain_en;
    logic             rempty;
    logic [DW-1:0]    rdata;
    logic             rinc;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic [CNT_W-1:0] pop_count;

    afifo_rd_drain #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .drain_en  (drain_en),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .pop_count (pop_count)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic [DW-1:0] fifo[$];    // external FIFO contents, head at index 0
    exp_t          exp_q[$];   // words popped but not yet accepted downstream
    int            pops;       // pops since last reset
    int            pulses;     // observed rinc pulses in the current phase
    int            accepted;   // observed stream acceptances in the current phase
    bit            known;      // a reset edge has been seen
    bit            after_rst;  // buffer untouched since the last reset edge
    int            vectors;
    int            miscompares;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present FIFO head, check outputs against the model, advance the model.
    task automatic cycle();
        logic exp_rinc;
        logic exp_fire;
        logic [CNT_W-1:0] exp_cnt;
        rempty = (fifo.size() == 0);
        rdata  = rempty ? DW'($urandom()) : fifo[0];
        #1;
        exp_rinc = drain_en && !rempty && !rrst && (exp_q.size() < 2);
        check("rinc", rinc, exp_rinc);
        if (rinc) pulses++;
        if (known) begin
            exp_cnt = pops[CNT_W-1:0];
            check("m_valid", m_valid, exp_q.size() != 0);
            check("pop_count", pop_count, exp_cnt);
            if (exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0].data);
                check("m_last", m_last, exp_q[0].last);
            end else if (after_rst) begin
                check("rst_m_data", m_data, '0);
                check("rst_m_last", m_last, 1'b0);
            end
        end
        if (m_valid && m_ready) accepted++;
        exp_fire = (exp_q.size() != 0) && m_ready;
        @(posedge rclk);
        if (rrst) begin
            exp_q.delete();
            pops      = 0;
            known     = 1'b1;
            after_rst = 1'b1;
        end else begin
            if (exp_fire) void'(exp_q.pop_front());
            if (exp_rinc) begin
                exp_q.push_back('{data: fifo.pop_front(), last: (pops % BL) == BL - 1});
                pops++;
                after_rst = 1'b0;
            end
        end
        @(negedge rclk);
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pops        = 0;
        pulses      = 0;
        accepted    = 0;
        known       = 1'b0;
        after_rst   = 1'b0;
        rrst        = 1'b1;
        drain_en    = 1'b0;
        m_ready     = 1'b0;
        rempty      = 1'b1;
        rdata       = '0;
        @(negedge rclk);

        // Reset held for three cycles, then a single word.
        repeat (3) cycle();
        rrst = 1'b0;
        fifo.push_back(32'hA5A5_0001);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        pulses   = 0;
        repeat (4) cycle();
        check("single_pulses", pulses, 1);
        check("single_count", pop_count, 1);

        // Streaming burst of 0..9.
        do_reset();
        for (int i = 0; i < 10; i++) fifo.push_back(DW'(i));
        pulses = 0;
        repeat (12) cycle();
        check("stream_pulses", pulses, 10);
        check("stream_count", pop_count, 10);

        // Backpressure for five cycles, then release.
        do_reset();
        for (int i = 0; i < 12; i++) fifo.push_back(DW'($urandom()));
        m_ready  = 1'b0;
        pulses   = 0;
        accepted = 0;
        repeat (5) cycle();
        check("bp_pulses", pulses, 2);
        m_ready = 1'b1;
        repeat (14) cycle();
        check("bp_accepted", accepted, 12);

        // Disable at beat 2, drain, re-enable, then run the FIFO empty.
        do_reset();
        for (int i = 0; i < 8; i++) fifo.push_back(DW'(32'h100 + i));
        for (int k = 0; k < 20 && pops < 2; k++) cycle();
        check("dis_count", pop_count, 2);
        drain_en = 1'b0;
        repeat (4) cycle();
        check("dis_drained", m_valid, 1'b0);
        drain_en = 1'b1;
        repeat (12) cycle();
        check("dis_total", pop_count, 8);

        // Reset with the buffer full at beat 2.
        do_reset();
        for (int i = 0; i < 6; i++) fifo.push_back(DW'(32'h200 + i));
        m_ready = 1'b0;
        for (int k = 0; k < 20 && pops < 2; k++) cycle();
        check("midrst_full", m_valid, 1'b1);
        rrst = 1'b1;
        cycle();
        check("midrst_valid", m_valid, 1'b0);
        check("midrst_count", pop_count, 0);
        check("midrst_rinc", rinc, 1'b0);
        rrst    = 1'b0;
        m_ready = 1'b1;
        repeat (8) cycle();

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (fifo.size() < 6 && $urandom_range(0, 2) != 0) fifo.push_back(DW'($urandom()));
            drain_en = ($urandom_range(0, 7) != 0);
            m_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain_en = 1'b1;
        m_ready  = 1'b1;
        repeat (12) cycle();
        check("rand_drained", m_valid, 1'b0);

        // Pop-count wrap at 4 bits.
        do_reset();
        fifo.delete();
        for (int i = 0; i < 17; i++) fifo.push_back(DW'($urandom()));
        repeat (20) cycle();
        check("wrap_count", pop_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
